// File: rtl/cnn_result_reader.sv
// Reader for the layer-2 CNN result port: issues credit-limited ReadEn strobes, captures
// ConvResult after READ_LAT cycles into a small FIFO and streams it out. Option: RESULT_RELU_EN.
module cnn_result_reader #(
  parameter int RES_W       = 22,
  parameter int NUM_RESULTS = 4,
  parameter int READ_LAT    = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    ReadEn,
  input  logic signed [RES_W-1:0] ConvResult,
  output logic signed [RES_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(NUM_RESULTS + 1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] NUM_C   = IW'(NUM_RESULTS);

  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           issued_q, issued_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           inflight_q, inflight_d;
  logic [READ_LAT-1:0]     lat_q, lat_d;
  logic                    readen_q, readen_d;
  logic                    done_q, done_d;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic signed [RES_W-1:0] mem [FIFO_DEPTH];

  logic                    push, pop, credit_ok;
  logic signed [RES_W-1:0] push_data;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign push      = lat_q[READ_LAT-1];
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign busy      = (state_q != IDLE);
  assign ReadEn    = readen_q;
  assign done      = done_q;

`ifdef RESULT_RELU_EN
  assign push_data = ConvResult[RES_W-1] ? '0 : ConvResult;
`else
  assign push_data = ConvResult;
`endif

  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    inflight_d = inflight_q + CW'(readen_q) - CW'(push);
    // Every outstanding strobe is a reserved FIFO slot, so a push can never find it full.
    credit_ok  = (({1'b0, count_d} + {1'b0, inflight_d}) < DEPTH_C);

    lat_d[0] = readen_q;
    for (int i = 1; i < READ_LAT; i++) begin
      lat_d[i] = lat_q[i-1];
    end

    state_d  = state_q;
    issued_d = issued_q + IW'(readen_q);
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = READ;
          issued_d = '0;
        end
      end
      READ: begin
        if (issued_q == NUM_C) state_d = FLUSH;
      end
      FLUSH: begin
        if ((inflight_q == '0) && (count_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    readen_d = (state_d == READ) && (issued_d < NUM_C) && credit_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      lat_q      <= '0;
      readen_q   <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      lat_q      <= lat_d;
      readen_q   <= readen_d;
      done_q     <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage carries no reset: entries are only visible through out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_cnn_result_reader.sv
// Bench for cnn_result_reader: two instances (default, READ_LAT=3/FIFO_DEPTH=2), a CNN
// latency model, a scoreboard queue and a table of frames. Honours RESULT_RELU_EN.
module tb_cnn_result_reader;

  localparam int RW = 22;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] start_v, ready_v, readen_v, valid_v, busy_v, done_v;
  logic signed [RW-1:0] conv_v [2];
  logic signed [RW-1:0] data_v [2];

  always #5 clk = ~clk;

  cnn_result_reader #(.RES_W(RW), .NUM_RESULTS(4), .READ_LAT(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .ReadEn(readen_v[0]),
    .ConvResult(conv_v[0]), .out_data(data_v[0]), .out_valid(valid_v[0]),
    .out_ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  cnn_result_reader #(.RES_W(RW), .NUM_RESULTS(4), .READ_LAT(3), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .ReadEn(readen_v[1]),
    .ConvResult(conv_v[1]), .out_data(data_v[1]), .out_valid(valid_v[1]),
    .out_ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  typedef struct {
    int                   sel;
    int                   mode;   // 0: ready high, 1: ready low until hold, 2: random
    int                   hold;
    int                   xstart;
    logic [3:0][RW-1:0]   vals;
    logic [3:0][RW-1:0]   exps;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int re_cnt, hs_cnt, done_cnt, cur_run, max_run, max_out, re_at_hold;

  logic signed [RW-1:0] src_q [$];
  logic signed [RW-1:0] xsrc_q [$];
  logic signed [RW-1:0] exp_q [$];
  logic signed [RW-1:0] pipe [2][3];
  vec_t tbl [7];

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  function automatic int depth_of(input int sel);
    return (sel == 0) ? 4 : 2;
  endfunction

  function automatic vec_t mk(input int sel, input int mode, input int hold, input int xs,
                              input int a, input int b, input int c, input int d);
    vec_t r;
    int arr [4];
    arr = '{a, b, c, d};
    r.sel = sel; r.mode = mode; r.hold = hold; r.xstart = xs;
    for (int i = 0; i < 4; i++) begin
      r.vals[i] = RW'(arr[i]);
`ifdef RESULT_RELU_EN
      r.exps[i] = (arr[i] < 0) ? '0 : RW'(arr[i]);
`else
      r.exps[i] = RW'(arr[i]);
`endif
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic clear_counters();
    re_cnt = 0; hs_cnt = 0; done_cnt = 0; cur_run = 0; max_run = 0; max_out = 0;
    re_at_hold = -1;
  endtask

  // One clock cycle: drive at posedge+1, sample at negedge, advance the CNN model.
  task automatic step(input int sel, input bit rdy, input bit strt);
    bit strobe;
    logic signed [RW-1:0] e;
    start_v      = 2'b00;
    start_v[sel] = strt;
    ready_v      = 2'b11;
    ready_v[sel] = rdy;
    @(negedge clk);
    strobe = readen_v[sel];
    if (strobe) begin
      re_cnt++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    if (valid_v[sel] && ready_v[sel]) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", data_v[sel], 0);
        chk("scoreboard_empty_at_handshake", 0, 1 - hs_cnt + hs_cnt);
      end else begin
        e = exp_q.pop_front();
        $display("dut%0d handshake %0d: data=%0d expected=%0d", sel, hs_cnt, data_v[sel], e);
        chk("out_data", data_v[sel], e);
      end
    end
    if (done_v[sel]) begin
      done_cnt++;
      chk("busy_at_done", busy_v[sel], 0);
    end
    if (re_cnt - hs_cnt > max_out) max_out = re_cnt - hs_cnt;
    @(posedge clk);
    #1;
    for (int k = 2; k > 0; k--) pipe[sel][k] = pipe[sel][k-1];
    pipe[sel][0] = RW'($urandom);
    if (strobe && src_q.size() > 0) begin
      pipe[sel][0] = src_q.pop_front();
      exp_q.push_back(xsrc_q.pop_front());
    end
    conv_v[sel]     = pipe[sel][lat_of(sel)-1];
    conv_v[1 - sel] = RW'($urandom);
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    bit rdy, strt;
    int post;
    src_q.delete(); xsrc_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(v.vals[i]);
      xsrc_q.push_back(v.exps[i]);
    end
    clear_counters();
    post = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      case (v.mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc >= v.hold);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      strt = (cyc == 0) || ((v.xstart != 0) && (cyc == 2 || cyc == 3));
      step(v.sel, rdy, strt);
      if (cyc == 0) chk("busy_after_start", busy_v[v.sel], 1);
      if (v.mode == 1 && cyc == v.hold - 1) re_at_hold = re_cnt;
      if (done_cnt > 0) post++;
      if (post == 4) break;
    end
    $display("frame %0d dut%0d: readen=%0d handshakes=%0d done=%0d max_outstanding=%0d",
             idx, v.sel, re_cnt, hs_cnt, done_cnt, max_out);
    chk("readen_count", re_cnt, 4);
    chk("handshake_count", hs_cnt, 4);
    chk("done_count", done_cnt, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("busy_after_done", busy_v[v.sel], 0);
    chk("credit_bound_exceeded", (max_out > depth_of(v.sel)) ? 1 : 0, 0);
    if (v.mode == 0 && v.sel == 0) chk("readen_back_to_back", max_run, 4);
    if (v.mode == 1) chk("readen_stall_at_depth", re_at_hold, (depth_of(v.sel) < 4) ? depth_of(v.sel) : 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(0, 0, 0, 0, 100, -5, 0, 2097151);
    tbl[1] = mk(0, 0, 0, 0, -1, -2097152, 7, 0);
    tbl[2] = mk(0, 1, 12, 0, 1234, -4321, 555, -1);
    tbl[3] = mk(0, 0, 0, 1, 9, 8, -7, 6);
    tbl[4] = mk(1, 1, 15, 0, -100, 200, -300, 400);
    tbl[5] = mk(1, 2, 0, 0, 1, 2, 3, 4);
    tbl[6] = mk(1, 2, 0, 0, -2097152, 2097151, -1, 1);

    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 3; k++) pipe[s][k] = '0;
    rst_n   = 1'b0;
    start_v = 2'b00;
    ready_v = 2'b00;
    conv_v[0] = '0;
    conv_v[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_readen", readen_v[s], 0);
      chk("reset_out_valid", valid_v[s], 0);
      chk("reset_busy", busy_v[s], 0);
      chk("reset_done", done_v[s], 0);
      chk("reset_out_data", data_v[s], 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_frame(i, tbl[i]);

    // Reset in the middle of a frame with two results already buffered.
    src_q.delete(); xsrc_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(RW'(11 * (i + 1)));
      xsrc_q.push_back(RW'(11 * (i + 1)));
    end
    clear_counters();
    for (int c = 0; c < 4; c++) step(0, 1'b0, c == 0);
    chk("midframe_readen_high", readen_v[0], 1);
    chk("midframe_busy_high", busy_v[0], 1);
    chk("midframe_out_valid", valid_v[0], 1);
    rst_n = 1'b0;
    #1;
    $display("async reset: readen=%0d valid=%0d busy=%0d done=%0d",
             readen_v[0], valid_v[0], busy_v[0], done_v[0]);
    chk("async_reset_readen", readen_v[0], 0);
    chk("async_reset_out_valid", valid_v[0], 0);
    chk("async_reset_busy", busy_v[0], 0);
    chk("async_reset_done", done_v[0], 0);
    src_q.delete(); xsrc_q.delete(); exp_q.delete();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 3; k++) pipe[s][k] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(7, mk(0, 0, 0, 0, 31, -32, 33, -34));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
